// File: rtl/sr_pkg.sv
// Shared types for the set/reset command generator.
// Contents: FSM state encoding and the command selector.
// No logic; imported by sr_debounce and sr_cmd_gen.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        LOCKOUT = 2'd2
    } sr_state_t;

    typedef enum logic {
        CMD_SET = 1'b0,
        CMD_CLR = 1'b1
    } sr_cmd_t;

endpackage

// File: rtl/sr_debounce.sv
// Two-FF synchroniser, debounce counter and rising-edge pulse for one raw request line.
// Ports: clk, reset_n (async active-low), req (raw, asynchronous), rise (one-cycle registered pulse).
// Latency: rise is visible in the cycle after edge k+DEBOUNCE_CYCLES+2 for a raw level first sampled at edge k.
module sr_debounce
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    output logic rise
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    // The counter stops at CNT_MAX: reaching it toggles the level and clears,
    // so it can never wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            sync_a <= req;
            sync_b <= sync_a;
            rise   <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= ~level;
                cnt   <= '0;
                rise  <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sr_cmd_gen.sv
// Debounced set/clear requests -> rate-limited, mutually exclusive s/r commands with a one-cycle en strobe.
// Ports: clk, reset_n (async active-low), set_req/clr_req (raw), s/r/en/busy/conflict (registered).
// Latency: en one cycle after the pending flag is seen in IDLE; at most one command per LOCKOUT_CYCLES+1 cycles.
module sr_cmd_gen
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic en,
    output logic busy,
    output logic conflict
);

    localparam int            LW        = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

    logic          set_rise;
    logic          clr_rise;
    sr_state_t     state;
    sr_state_t     state_n;
    sr_cmd_t       cmd_n;
    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_cnt_n;
    logic          set_pend;
    logic          clr_pend;
    logic          set_pend_n;
    logic          clr_pend_n;
    logic          arb;
    logic          s_n;
    logic          r_n;
    logic          en_n;
    logic          busy_n;
    logic          conflict_n;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (set_req),
        .rise    (set_rise)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (clr_req),
        .rise    (clr_rise)
    );

    always_comb begin
        state_n    = state;
        lock_cnt_n = lock_cnt;
        cmd_n      = CMD_SET;
        set_pend_n = set_pend;
        clr_pend_n = clr_pend;
        conflict_n = 1'b0;
        arb        = 1'b0;

        case (state)
            IDLE: arb = 1'b1;
            ISSUE: begin
                state_n    = LOCKOUT;
                lock_cnt_n = LOCK_LOAD;
            end
            LOCKOUT: begin
                // The exit edge doubles as the IDLE arbitration point, so a request
                // that waited through lockout goes out with no idle gap.
                if (lock_cnt == '0) begin
                    state_n = IDLE;
                    arb     = 1'b1;
                end else begin
                    lock_cnt_n = lock_cnt - LW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Clear has priority; a set pending alongside it is dropped and flagged.
        if (arb) begin
            if (clr_pend) begin
                state_n    = ISSUE;
                cmd_n      = CMD_CLR;
                clr_pend_n = 1'b0;
                set_pend_n = 1'b0;
                conflict_n = set_pend;
            end else if (set_pend) begin
                state_n    = ISSUE;
                cmd_n      = CMD_SET;
                set_pend_n = 1'b0;
            end
        end

        // New edges are captured in every state; a second edge on a set flag is absorbed.
        set_pend_n = set_pend_n | set_rise;
        clr_pend_n = clr_pend_n | clr_rise;

        en_n   = (state_n == ISSUE);
        s_n    = en_n && (cmd_n == CMD_SET);
        r_n    = en_n && (cmd_n == CMD_CLR);
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lock_cnt <= '0;
            set_pend <= 1'b0;
            clr_pend <= 1'b0;
            s        <= 1'b0;
            r        <= 1'b0;
            en       <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state    <= state_n;
            lock_cnt <= lock_cnt_n;
            set_pend <= set_pend_n;
            clr_pend <= clr_pend_n;
            s        <= s_n;
            r        <= r_n;
            en       <= en_n;
            busy     <= busy_n;
            conflict <= conflict_n;
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen with default parameters.
// Reference: raw-sample history window decides debounced toggles; a request becomes eligible
// two edges after its debounced rise; commands are spaced by at least L+1 edges, clear first.
module tb_sr_cmd_gen;

    localparam int D  = 4;
    localparam int L  = 8;
    localparam int HN = D + 3;

    logic clk      = 1'b0;
    logic reset_n  = 1'b1;
    logic set_req  = 1'b0;
    logic clr_req  = 1'b0;
    logic s, r, en, busy, conflict;

    int vectors     = 0;
    int miscompares = 0;

    sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .s        (s),
        .r        (r),
        .en       (en),
        .busy     (busy),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int            ncyc       = 0;
    int            last_issue = -1000;
    logic [HN-1:0] hs, hc;           // raw samples, bit 0 = sampled at this edge
    bit            lvl_s, lvl_c, pend_s, pend_c, rise_s, rise_c;
    logic [4:0]    exp_o;            // {s, r, en, busy, conflict}

    task automatic model_reset();
        last_issue = -1000;
        hs = '0; hc = '0;
        lvl_s = 0; lvl_c = 0; pend_s = 0; pend_c = 0; rise_s = 0; rise_c = 0;
        exp_o = '0;
    endtask

    task automatic model_step();
        bit e_s, e_r, e_en, e_b, e_c;
        e_s = 0; e_r = 0; e_en = 0; e_c = 0;
        ncyc++;
        hs = {hs[HN-2:0], set_req};
        hc = {hc[HN-2:0], clr_req};
        if ((ncyc - last_issue) >= L + 1 && (pend_c || pend_s)) begin
            last_issue = ncyc;
            e_en = 1;
            if (pend_c) begin
                e_r = 1; e_c = pend_s; pend_c = 0; pend_s = 0;
            end else begin
                e_s = 1; pend_s = 0;
            end
        end
        e_b = (ncyc - last_issue) <= L;
        pend_s = pend_s | rise_s;
        pend_c = pend_c | rise_c;
        // level flips once D+1 consecutive synchronised samples disagree with it
        rise_s = 0;
        if (hs[D+2:2] == {(D+1){~lvl_s}}) begin lvl_s = ~lvl_s; rise_s = lvl_s; end
        rise_c = 0;
        if (hc[D+2:2] == {(D+1){~lvl_c}}) begin lvl_c = ~lvl_c; rise_c = lvl_c; end
        exp_o = {e_s, e_r, e_en, e_b, e_c};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int en_cnt;
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({s, r, en, busy, conflict} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_init: outputs=%b expected 00000", {s, r, en, busy, conflict});
        end
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_req = 1'b1;
            tick();
            vectors++;
            if ({s, r, en, busy, conflict} !== exp_o) begin
                miscompares++;
                $display("FAIL reset_pre i=%0d: got %b expected %b", i, {s, r, en, busy, conflict}, exp_o);
            end
        end
        vectors++;
        if (busy !== 1'b1 || en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_lockout: busy=%b en=%b expected busy=1 en=0", busy, en);
        end
        set_req = 1'b0;
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if ({s, r, en, busy, conflict} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_async: outputs=%b expected 00000", {s, r, en, busy, conflict});
        end
        @(negedge clk) reset_n = 1'b1;
        en_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (en) en_cnt++;
            vectors++;
            if ({s, r, en, busy, conflict} !== exp_o) begin
                miscompares++;
                $display("FAIL reset_post i=%0d: got %b expected %b", i, {s, r, en, busy, conflict}, exp_o);
            end
        end
        vectors++;
        if (en_cnt !== 0) begin
            miscompares++;
            $display("FAIL reset_quiet: en pulses=%0d expected 0", en_cnt);
        end
    endtask

    task automatic test_single_set();
        int en_at, busy_cnt, en_cnt;
        en_at = -1; busy_cnt = 0; en_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            set_req = (i < 20);
            tick();
            if (en) begin en_cnt++; if (en_at < 0) en_at = i; end
            if (busy) busy_cnt++;
            vectors++;
            if ({s, r, en, busy, conflict} !== exp_o) begin
                miscompares++;
                $display("FAIL single_model i=%0d: got %b expected %b", i, {s, r, en, busy, conflict}, exp_o);
            end
            if (i == 8) begin
                vectors++;
                if ({s, r, en} !== 3'b101) begin
                    miscompares++;
                    $display("FAIL single_cmd: s r en=%b expected 101", {s, r, en});
                end
            end
        end
        vectors++;
        if (en_at !== 8 || en_cnt !== 1 || busy_cnt !== 9) begin
            miscompares++;
            $display("FAIL single_timing: en_at=%0d en_cnt=%0d busy_cycles=%0d expected 8 1 9", en_at, en_cnt, busy_cnt);
        end
    endtask

    task automatic test_glitch();
        int early_en, conf_cnt, s_cnt;
        early_en = 0; conf_cnt = 0; s_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            set_req = (i < 3) || (i >= 20 && i < 25);
            tick();
            if (en && i < 20) early_en++;
            if (conflict) conf_cnt++;
            if (s) s_cnt++;
            vectors++;
            if ({s, r, en, busy, conflict} !== exp_o) begin
                miscompares++;
                $display("FAIL glitch_model i=%0d: got %b expected %b", i, {s, r, en, busy, conflict}, exp_o);
            end
        end
        vectors++;
        if (early_en !== 0 || conf_cnt !== 0 || s_cnt !== 1) begin
            miscompares++;
            $display("FAIL glitch: early_en=%0d conflicts=%0d s_cmds=%0d expected 0 0 1", early_en, conf_cnt, s_cnt);
        end
    endtask

    task automatic test_simultaneous();
        int r_cnt, s_cnt, conf_cnt, both;
        r_cnt = 0; s_cnt = 0; conf_cnt = 0; both = 0;
        for (int i = 0; i < 40; i++) begin
            set_req = (i < 10);
            clr_req = (i < 10);
            tick();
            if (r) r_cnt++;
            if (s) s_cnt++;
            if (conflict) conf_cnt++;
            if (conflict && en && r) both++;
            vectors++;
            if ({s, r, en, busy, conflict} !== exp_o) begin
                miscompares++;
                $display("FAIL simul_model i=%0d: got %b expected %b", i, {s, r, en, busy, conflict}, exp_o);
            end
        end
        vectors++;
        if (r_cnt !== 1 || s_cnt !== 0 || conf_cnt !== 1 || both !== 1) begin
            miscompares++;
            $display("FAIL simultaneous: r=%0d s=%0d conflict=%0d aligned=%0d expected 1 0 1 1", r_cnt, s_cnt, conf_cnt, both);
        end
    endtask

    task automatic test_lockout_queue();
        int r_at, s_at, r2_at, s2_at, s2_cnt;
        r_at = -1; s_at = -1; r2_at = -1; s2_at = -1; s2_cnt = 0;
        for (int i = 0; i < 90; i++) begin
            clr_req = (i < 10) || (i >= 40 && i < 50);
            // second set burst has a 2-cycle dropout: two raw edges, one real request
            set_req = (i >= 5 && i < 15) || (i >= 44 && i < 49) || (i >= 51 && i < 56);
            tick();
            if (r && i < 40 && r_at < 0) r_at = i;
            if (s && i < 40 && s_at < 0) s_at = i;
            if (r && i >= 40 && r2_at < 0) r2_at = i;
            if (s && i >= 40) begin s2_cnt++; if (s2_at < 0) s2_at = i; end
            vectors++;
            if ({s, r, en, busy, conflict} !== exp_o) begin
                miscompares++;
                $display("FAIL queue_model i=%0d: got %b expected %b", i, {s, r, en, busy, conflict}, exp_o);
            end
        end
        vectors++;
        if (r_at !== 8 || s_at !== 17) begin
            miscompares++;
            $display("FAIL queue_spacing: r_at=%0d s_at=%0d expected 8 17", r_at, s_at);
        end
        vectors++;
        if (r2_at !== 48 || s2_at !== 57 || s2_cnt !== 1) begin
            miscompares++;
            $display("FAIL queue_absorb: r_at=%0d s_at=%0d s_cmds=%0d expected 48 57 1", r2_at, s2_at, s2_cnt);
        end
    endtask

    task automatic test_held_reset();
        int r_at;
        r_at = -1;
        clr_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if ({s, r, en, busy, conflict} !== exp_o) begin
                miscompares++;
                $display("FAIL held_pre i=%0d: got %b expected %b", i, {s, r, en, busy, conflict}, exp_o);
            end
        end
        #2 reset_n = 1'b0;
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            clr_req = (i < 25);
            tick();
            if (r && r_at < 0) r_at = i;
            vectors++;
            if ({s, r, en, busy, conflict} !== exp_o) begin
                miscompares++;
                $display("FAIL held_post i=%0d: got %b expected %b", i, {s, r, en, busy, conflict}, exp_o);
            end
        end
        vectors++;
        if (r_at !== 8) begin
            miscompares++;
            $display("FAIL held_reset: r_at=%0d expected 8", r_at);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) set_req = ~set_req;
            if ($urandom_range(5) == 0) clr_req = ~clr_req;
            tick();
            vectors++;
            if ({s, r, en, busy, conflict} !== exp_o) begin
                miscompares++;
                $display("FAIL random_model i=%0d: got %b expected %b", i, {s, r, en, busy, conflict}, exp_o);
            end
            if ($urandom_range(399) == 0) begin
                #2 reset_n = 1'b0;
                model_reset();
                #1;
                vectors++;
                if ({s, r, en, busy, conflict} !== 5'b0) begin
                    miscompares++;
                    $display("FAIL random_reset i=%0d: outputs=%b expected 00000", i, {s, r, en, busy, conflict});
                end
                #1 reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_glitch();
        test_simultaneous();
        test_lockout_queue();
        test_held_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
